// File: rtl/control_pipe.sv
// -----------------------------------------------------------------------------
// control_pipe
//   Decode-stage control unit for the cpu32 core. It turns the opcode into the
//   7-bit control word in the same cycle. It also keeps three pieces of state:
//     - a register-write scoreboard that stalls on read-after-write hazards
//     - a branch-squash down-counter that drops slots after a taken branch
//     - a saturating count of hazard-stall cycles
//
// Optional build macro:
//   CTL_FORWARD_EN - a non-load producer in scoreboard entry 0 is forwarded
//                    (fwd_a/fwd_b) instead of stalling. When the macro is not
//                    defined, every scoreboard match stalls and fwd_a/fwd_b
//                    are tied low.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   in_valid            instruction present at decode
//   opcode, opfunc      instruction opcode and ALU function
//   ra, rb, rd          source A, source B and destination register addresses
//   ctl_adata_zero      source A data is zero (branch condition)
//   in_ready            decode consumes the instruction this cycle
//   issue               instruction issued with a live control word
//   ctl_*               control word, ALU function and branch controls
//   fwd_a, fwd_b        forward the ALU result to source A / source B
//   stall_count         saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module control_pipe #(
  parameter int RADDR_W     = 4,
  parameter int WB_DEPTH    = 2,
  parameter int BR_SQUASH   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [3:0]             opcode,
  input  logic [3:0]             opfunc,
  input  logic [RADDR_W-1:0]     ra,
  input  logic [RADDR_W-1:0]     rb,
  input  logic [RADDR_W-1:0]     rd,
  input  logic                   ctl_adata_zero,
  output logic                   in_ready,
  output logic                   issue,
  output logic                   ctl_alu_pc,
  output logic                   ctl_alu_imm,
  output logic                   ctl_regs_we,
  output logic                   ctl_ram_we,
  output logic                   ctl_alu_altdest,
  output logic                   ctl_wdata_ram,
  output logic [3:0]             ctl_alu_func,
  output logic                   ctl_branch_ind,
  output logic                   ctl_branch_taken,
  output logic                   fwd_a,
  output logic                   fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Control word bit order: {alu_pc, alu_imm, regs_we, ram_we, altdest,
  // branch_op, wdata_ram}.
  localparam logic [6:0] NOP_WORD = 7'b1100000;
  localparam logic [2:0] SQ_INIT  = 3'(BR_SQUASH);

  // Scoreboard: entry 0 holds the instruction issued last cycle, and each
  // higher entry is one cycle older.
  logic [WB_DEPTH-1:0]              r_sb_vld;
  logic [WB_DEPTH-1:0][RADDR_W-1:0] r_sb_dst;
`ifdef CTL_FORWARD_EN
  logic [WB_DEPTH-1:0]              r_sb_ld;
`endif

  logic [2:0]             r_sq_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic [6:0]         w_dec;
  logic               w_rd_a;
  logic               w_rd_b;
  logic [RADDR_W-1:0] w_src_b;
  logic               w_a_new;
  logic               w_b_new;
  logic               w_a_old;
  logic               w_b_old;
  logic               w_hazard;
  logic               w_fwd_a;
  logic               w_fwd_b;
  logic               w_squashing;
  logic               w_issue;
  logic               w_stall;
  logic               w_taken;
  logic [6:0]         w_word;

  // Opcode decode, including which sources the instruction really reads.
  // SW reads rd as its store data, so rd is source B for opcode 3.
  always_comb begin
    w_dec   = 7'b0000000;
    w_rd_a  = 1'b0;
    w_rd_b  = 1'b0;
    w_src_b = rb;
    case (opcode)
      4'd0: begin
        w_dec  = 7'b0010000;
        w_rd_a = 1'b1;
        w_rd_b = 1'b1;
      end
      4'd1: begin
        w_dec  = 7'b0110100;
        w_rd_a = 1'b1;
      end
      4'd2: begin
        w_dec  = 7'b0110101;
        w_rd_a = 1'b1;
      end
      4'd3: begin
        w_dec   = 7'b0101000;
        w_rd_a  = 1'b1;
        w_rd_b  = 1'b1;
        w_src_b = rd;
      end
      4'd4, 4'd5: begin
        w_dec  = 7'b1010110;
        w_rd_a = 1'b1;
      end
      4'd6, 4'd7: begin
        w_dec  = 7'b1010010;
        w_rd_a = 1'b1;
        w_rd_b = 1'b1;
      end
      4'd14:   w_dec = NOP_WORD;
      default: w_dec = 7'b0000000;
    endcase
  end

  // Source matches are split into entry 0 and the older entries because only
  // entry 0 can be forwarded. Register 0 never matches.
  always_comb begin
    w_a_new = 1'b0;
    w_b_new = 1'b0;
    w_a_old = 1'b0;
    w_b_old = 1'b0;
    if (w_rd_a && (ra != '0)) begin
      w_a_new = r_sb_vld[0] && (r_sb_dst[0] == ra);
      for (int i = 1; i < WB_DEPTH; i++) begin
        if (r_sb_vld[i] && (r_sb_dst[i] == ra)) w_a_old = 1'b1;
      end
    end
    if (w_rd_b && (w_src_b != '0)) begin
      w_b_new = r_sb_vld[0] && (r_sb_dst[0] == w_src_b);
      for (int i = 1; i < WB_DEPTH; i++) begin
        if (r_sb_vld[i] && (r_sb_dst[i] == w_src_b)) w_b_old = 1'b1;
      end
    end
  end

`ifdef CTL_FORWARD_EN
  // A load in entry 0 has no data yet, so that case still stalls.
  assign w_hazard = in_valid &
                    (((w_a_new | w_b_new) & r_sb_ld[0]) | w_a_old | w_b_old);
  assign w_fwd_a  = w_a_new & ~r_sb_ld[0];
  assign w_fwd_b  = w_b_new & ~r_sb_ld[0];
`else
  assign w_hazard = in_valid & (w_a_new | w_b_new | w_a_old | w_b_old);
  assign w_fwd_a  = 1'b0;
  assign w_fwd_b  = 1'b0;
`endif

  // Squash has priority over a hazard. A squashed slot is consumed and dropped.
  assign w_squashing = (r_sq_cnt != 3'd0);
  assign w_issue     = rst_n & in_valid & ~w_squashing & ~w_hazard;
  assign w_stall     = rst_n & ~w_squashing & w_hazard;
  assign w_word      = w_issue ? w_dec : NOP_WORD;
  assign w_taken     = w_issue & w_dec[1] & (ctl_adata_zero != opcode[0]);

  assign in_ready         = rst_n & (w_squashing | (in_valid & ~w_hazard));
  assign issue            = w_issue;
  assign ctl_alu_pc       = w_word[6];
  assign ctl_alu_imm      = w_word[5];
  assign ctl_regs_we      = w_word[4];
  assign ctl_ram_we       = w_word[3];
  assign ctl_alu_altdest  = w_word[2];
  assign ctl_wdata_ram    = w_word[0];
  assign ctl_alu_func     = w_issue ? opfunc : 4'd0;
  assign ctl_branch_ind   = opcode[1] & w_issue;
  assign ctl_branch_taken = w_taken;
  assign fwd_a            = w_issue & w_fwd_a;
  assign fwd_b            = w_issue & w_fwd_b;
  assign stall_count      = r_stall_cnt;

  // The scoreboard shifts every cycle. A stalled or squashed slot enters the
  // scoreboard as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_vld <= '0;
      r_sb_dst <= '0;
`ifdef CTL_FORWARD_EN
      r_sb_ld  <= '0;
`endif
    end else begin
      for (int i = WB_DEPTH - 1; i > 0; i--) begin
        r_sb_vld[i] <= r_sb_vld[i-1];
        r_sb_dst[i] <= r_sb_dst[i-1];
`ifdef CTL_FORWARD_EN
        r_sb_ld[i]  <= r_sb_ld[i-1];
`endif
      end
      r_sb_vld[0] <= w_issue & w_dec[4] & (rd != '0);
      r_sb_dst[0] <= rd;
`ifdef CTL_FORWARD_EN
      r_sb_ld[0]  <= (opcode == 4'd2);
`endif
    end
  end

  // Squash down-counter. A taken branch can only occur while the counter is
  // zero, because squashing blocks issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq_cnt <= 3'd0;
    end else if (w_taken) begin
      r_sq_cnt <= SQ_INIT;
    end else if (w_squashing) begin
      r_sq_cnt <= r_sq_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

  localparam int RADDR_W     = 4;
  localparam int WB_DEPTH    = 2;
  localparam int BR_SQUASH   = 1;
  localparam int STALL_CNT_W = 4;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;
  localparam logic [6:0] NOP_W = 7'b1100000;
`ifdef CTL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic [3:0]             opcode;
  logic [3:0]             opfunc;
  logic [RADDR_W-1:0]     ra;
  logic [RADDR_W-1:0]     rb;
  logic [RADDR_W-1:0]     rd;
  logic                   ctl_adata_zero;
  logic                   in_ready;
  logic                   issue;
  logic                   ctl_alu_pc;
  logic                   ctl_alu_imm;
  logic                   ctl_regs_we;
  logic                   ctl_ram_we;
  logic                   ctl_alu_altdest;
  logic                   ctl_wdata_ram;
  logic [3:0]             ctl_alu_func;
  logic                   ctl_branch_ind;
  logic                   ctl_branch_taken;
  logic                   fwd_a;
  logic                   fwd_b;
  logic [STALL_CNT_W-1:0] stall_count;

  control_pipe #(
    .RADDR_W(RADDR_W),
    .WB_DEPTH(WB_DEPTH),
    .BR_SQUASH(BR_SQUASH),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .opcode(opcode),
    .opfunc(opfunc),
    .ra(ra),
    .rb(rb),
    .rd(rd),
    .ctl_adata_zero(ctl_adata_zero),
    .in_ready(in_ready),
    .issue(issue),
    .ctl_alu_pc(ctl_alu_pc),
    .ctl_alu_imm(ctl_alu_imm),
    .ctl_regs_we(ctl_regs_we),
    .ctl_ram_we(ctl_ram_we),
    .ctl_alu_altdest(ctl_alu_altdest),
    .ctl_wdata_ram(ctl_wdata_ram),
    .ctl_alu_func(ctl_alu_func),
    .ctl_branch_ind(ctl_branch_ind),
    .ctl_branch_taken(ctl_branch_taken),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: time-stamped history of register writes and taken
  // branches. A write issued at cycle t blocks readers for the next WB_DEPTH
  // cycles, and a taken branch drops the next BR_SQUASH slots.
  int m_t;
  int m_wr_t[$];
  int m_wr_d[$];
  bit m_wr_ld[$];
  int m_br_t;
  int m_stall;
  bit e_ready;

  function automatic logic [6:0] decode(input logic [3:0] op);
    case (op)
      4'd0:       return 7'b0010000;
      4'd1:       return 7'b0110100;
      4'd2:       return 7'b0110101;
      4'd3:       return 7'b0101000;
      4'd4, 4'd5: return 7'b1010110;
      4'd6, 4'd7: return 7'b1010010;
      4'd14:      return NOP_W;
      default:    return 7'b0000000;
    endcase
  endfunction

  function automatic bit reads_a(input logic [3:0] op);
    return op <= 4'd7;
  endfunction

  function automatic bit reads_b(input logic [3:0] op);
    return op == 4'd0 || op == 4'd3 || op == 4'd6 || op == 4'd7;
  endfunction

  task automatic model_clear();
    m_wr_t.delete();
    m_wr_d.delete();
    m_wr_ld.delete();
    m_br_t  = -100;
    m_stall = 0;
  endtask

  task automatic step(input bit v, input logic [3:0] op, input logic [3:0] fn,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                      input bit z, input bit rst);
    bit sq, hz, fa, fb, e_issue, e_taken, e_ind;
    logic [6:0] e_word;
    logic [3:0] e_func;
    logic [3:0] sb;
    in_valid = v; opcode = op; opfunc = fn; ra = a; rb = b; rd = d;
    ctl_adata_zero = z; rst_n = rst;
    @(negedge clk);
    while (m_wr_t.size() > 0 && (m_t - m_wr_t[0]) > WB_DEPTH) begin
      void'(m_wr_t.pop_front());
      void'(m_wr_d.pop_front());
      void'(m_wr_ld.pop_front());
    end
    if (!rst) model_clear();
    sq = rst && (m_t - m_br_t) >= 1 && (m_t - m_br_t) <= BR_SQUASH;
    sb = (op == 4'd3) ? d : b;
    hz = 0; fa = 0; fb = 0;
    for (int k = 0; k < m_wr_t.size(); k++) begin
      bit ma, mb;
      ma = reads_a(op) && a != 0 && a == m_wr_d[k][3:0];
      mb = reads_b(op) && sb != 0 && sb == m_wr_d[k][3:0];
      if (ma || mb) begin
        if (FWD && (m_t - m_wr_t[k]) == 1 && !m_wr_ld[k]) begin
          fa |= ma;
          fb |= mb;
        end else begin
          hz = 1;
        end
      end
    end
    hz      = hz && v && rst;
    e_issue = rst && v && !sq && !hz;
    e_ready = rst && (sq || (v && !hz));
    e_word  = e_issue ? decode(op) : NOP_W;
    e_taken = e_issue && e_word[1] && (z != op[0]);
    e_ind   = e_issue && op[1];
    e_func  = e_issue ? fn : 4'd0;
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("issue", 32'(issue), 32'(e_issue));
    check("ctl_word", 32'({ctl_alu_pc, ctl_alu_imm, ctl_regs_we, ctl_ram_we,
                           ctl_alu_altdest, ctl_wdata_ram}),
          32'({e_word[6:2], e_word[0]}));
    check("alu_func", 32'(ctl_alu_func), 32'(e_func));
    check("branch_ind", 32'(ctl_branch_ind), 32'(e_ind));
    check("branch_taken", 32'(ctl_branch_taken), 32'(e_taken));
    check("fwd_a", 32'(fwd_a), 32'(e_issue && fa));
    check("fwd_b", 32'(fwd_b), 32'(e_issue && fb));
    check("stall_count", 32'(stall_count), 32'(m_stall));
    @(posedge clk);
    if (rst) begin
      if (e_issue && e_word[4] && d != 0) begin
        m_wr_t.push_back(m_t);
        m_wr_d.push_back(int'(d));
        m_wr_ld.push_back(op == 4'd2);
      end
      if (e_taken) m_br_t = m_t;
      if (hz && !sq && m_stall < STALL_MAX) m_stall++;
    end
    m_t++;
    #1;
  endtask

  // Present one instruction until decode consumes it, within a cycle bound.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input bit z);
    int n;
    n = 0;
    do begin
      step(1, op, 4'(op + 4'd3), a, b, d, z, 1);
      n++;
    end while (!e_ready && n < 8);
    if (!e_ready) check("consume_bound", 32'(n), 32'(0));
  endtask

  logic [3:0] c_op, c_a, c_b, c_d;
  logic [3:0] c_fn;
  bit         c_v, c_z, c_rst;
  logic [3:0] op_tab [10];

  initial begin
    n_chk = 0; n_pass = 0; m_t = 0;
    model_clear();
    e_ready = 0;
    rst_n = 0; in_valid = 0; opcode = 0; opfunc = 0; ra = 0; rb = 0; rd = 0;
    ctl_adata_zero = 0;
    #1;
    step(1, 4'd1, 4'd2, 4'd1, 4'd0, 4'd3, 0, 0);
    step(0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0);

    // ALU imm writes r3, dependent ALU reg stalls for WB_DEPTH cycles.
    send(4'd1, 4'd1, 4'd0, 4'd3, 0);
    send(4'd0, 4'd3, 4'd2, 4'd4, 0);
    check("tp_stall_count", 32'(stall_count), 32'(2));
    // Register 0 is never tracked.
    send(4'd1, 4'd1, 4'd0, 4'd0, 0);
    send(4'd0, 4'd0, 4'd0, 4'd5, 0);
    // Taken relative branch, one squashed slot, then issue resumes.
    send(4'd4, 4'd1, 4'd0, 4'd7, 1);
    send(4'd0, 4'd1, 4'd2, 4'd6, 0);
    send(4'd1, 4'd1, 4'd0, 4'd6, 0);
    // Indirect branches that are not taken.
    send(4'd7, 4'd1, 4'd2, 4'd0, 1);
    send(4'd6, 4'd1, 4'd2, 4'd0, 0);
    // Producer-consumer pairs: ALU result, load, store data via rd.
    send(4'd0, 4'd1, 4'd2, 4'd5, 0);
    send(4'd0, 4'd5, 4'd2, 4'd8, 0);
    send(4'd2, 4'd1, 4'd0, 4'd5, 0);
    send(4'd0, 4'd5, 4'd0, 4'd9, 0);
    send(4'd1, 4'd1, 4'd0, 4'd10, 0);
    send(4'd3, 4'd2, 4'd0, 4'd10, 0);
    // Reset in the middle of a stall clears the scoreboard and the counter.
    send(4'd1, 4'd1, 4'd0, 4'd3, 0);
    step(1, 4'd0, 4'd1, 4'd3, 4'd2, 4'd4, 0, 1);
    step(1, 4'd0, 4'd1, 4'd3, 4'd2, 4'd4, 0, 0);
    check("rst_stall_count", 32'(stall_count), 32'(0));
    send(4'd0, 4'd3, 4'd2, 4'd4, 0);
    check("post_rst_ready", 32'(e_ready), 32'(1));

    // Randomized traffic; an instruction is held until decode consumes it.
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd14, 4'd9};
    c_v = 0; c_op = 0; c_a = 0; c_b = 0; c_d = 0; c_fn = 0; c_z = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_v || e_ready) begin
        c_v  = ($urandom_range(0, 99) < 85);
        c_op = op_tab[$urandom_range(0, 9)];
        c_a  = 4'($urandom_range(0, 3));
        c_b  = 4'($urandom_range(0, 3));
        c_d  = 4'($urandom_range(0, 3));
        c_fn = 4'($urandom_range(0, 15));
      end
      c_z   = 1'($urandom_range(0, 1));
      c_rst = ($urandom_range(0, 399) != 0);
      step(c_v, c_op, c_fn, c_a, c_b, c_d, c_z, c_rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
